// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between two requesters: round-robin grants, optional burst lock with timeout.
// Grants and BRAM drive are combinational; read data returns tagged to its requester RD_LAT cycles later.
module bram_port_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_lock,
    input  logic [31:0] r0_addr,
    input  logic [3:0]  r0_we,
    input  logic [31:0] r0_din,
    output logic        r0_gnt,
    output logic [31:0] r0_dout,
    output logic        r0_rvalid,
    input  logic        r1_req,
    input  logic        r1_lock,
    input  logic [31:0] r1_addr,
    input  logic [3:0]  r1_we,
    input  logic [31:0] r1_din,
    output logic        r1_gnt,
    output logic [31:0] r1_dout,
    output logic        r1_rvalid,
    output logic [31:0] BRAM_ADDR,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_EN,
    output logic        BRAM_RST,
    output logic [31:0] BRAM_DIN,
    input  logic [31:0] BRAM_DOUT,
    output logic        lock_err
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              prio_nxt;
    logic              lock_err_nxt;
    logic [15:0]       lock_cnt;
    logic              timeout;
    logic              rd_issue;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_id;

    assign timeout = (state != ARB) && (lock_cnt == 16'(MAX_LOCK - 1));

    always_comb begin
        r0_gnt       = 1'b0;
        r1_gnt       = 1'b0;
        state_nxt    = state;
        prio_nxt     = prio;
        lock_err_nxt = 1'b0;

        if (!rst) begin
            unique case (state)
                ARB: begin
                    if (r0_req && r1_req) begin
                        r0_gnt = !prio;
                        r1_gnt = prio;
                    end else begin
                        r0_gnt = r0_req;
                        r1_gnt = r1_req;
                    end
                end
                OWN0:    r0_gnt = r0_req;
                OWN1:    r1_gnt = r1_req;
                default: ;
            endcase
        end

        if (r0_gnt) begin
            prio_nxt = 1'b1;
        end else if (r1_gnt) begin
            prio_nxt = 1'b0;
        end

        // A transfer granted in the final locked cycle still completes; the timeout only ends ownership.
        unique case (state)
            ARB: begin
                if (r0_gnt && r0_lock) begin
                    state_nxt = OWN0;
                end else if (r1_gnt && r1_lock) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (r0_gnt && !r0_lock) begin
                    state_nxt = ARB;
                end else if (timeout) begin
                    state_nxt    = ARB;
                    lock_err_nxt = 1'b1;
                    prio_nxt     = 1'b1;
                end
            end
            OWN1: begin
                if (r1_gnt && !r1_lock) begin
                    state_nxt = ARB;
                end else if (timeout) begin
                    state_nxt    = ARB;
                    lock_err_nxt = 1'b1;
                    prio_nxt     = 1'b0;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            prio     <= 1'b0;
            lock_err <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_err <= lock_err_nxt;
            if (state != ARB && state_nxt == state) begin
                lock_cnt <= lock_cnt + 16'd1;
            end else begin
                lock_cnt <= '0;
            end
        end
    end

    always_comb begin
        BRAM_EN   = r0_gnt | r1_gnt;
        BRAM_ADDR = '0;
        BRAM_WE   = '0;
        BRAM_DIN  = '0;
        if (r1_gnt) begin
            BRAM_ADDR = r1_addr;
            BRAM_WE   = r1_we;
            BRAM_DIN  = r1_din;
        end else if (r0_gnt) begin
            BRAM_ADDR = r0_addr;
            BRAM_WE   = r0_we;
            BRAM_DIN  = r0_din;
        end
    end

    assign BRAM_RST = rst;
    assign rd_issue = (r0_gnt && r0_we == 4'd0) || (r1_gnt && r1_we == 4'd0);

    // The tag pipeline mirrors the BRAM read latency so each word returns to whoever issued it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_id[0]  <= r1_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    assign r0_rvalid = pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1];
    assign r1_rvalid = pipe_vld[RD_LAT-1] &&  pipe_id[RD_LAT-1];
    assign r0_dout   = BRAM_DOUT;
    assign r1_dout   = BRAM_DOUT;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives two arbiters (RD_LAT 1 and 3, MAX_LOCK 8) with identical directed traffic against behavioural BRAMs.
module tb_bram_port_arbiter;

    localparam int MAXL = 8;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_lock, r1_req, r1_lock;
    logic [31:0] r0_addr, r0_din, r1_addr, r1_din;
    logic [3:0]  r0_we, r1_we;

    logic        g0 [2];
    logic        g1 [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic [31:0] d0 [2];
    logic [31:0] d1 [2];
    logic [31:0] b_addr [2];
    logic [3:0]  b_we [2];
    logic        b_en [2];
    logic        b_rst [2];
    logic [31:0] b_din [2];
    logic [31:0] b_dout [2];
    logic        lerr [2];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem  [0:255];
        logic [31:0] pipe [0:3];

        bram_port_arbiter #(.RD_LAT(L), .MAX_LOCK(MAXL)) dut (
            .clk(clk), .rst(rst),
            .r0_req(r0_req), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_we(r0_we), .r0_din(r0_din),
            .r0_gnt(g0[g]), .r0_dout(d0[g]), .r0_rvalid(rv0[g]),
            .r1_req(r1_req), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_we(r1_we), .r1_din(r1_din),
            .r1_gnt(g1[g]), .r1_dout(d1[g]), .r1_rvalid(rv1[g]),
            .BRAM_ADDR(b_addr[g]), .BRAM_WE(b_we[g]), .BRAM_EN(b_en[g]), .BRAM_RST(b_rst[g]),
            .BRAM_DIN(b_din[g]), .BRAM_DOUT(b_dout[g]), .lock_err(lerr[g])
        );

        always @(posedge clk) begin
            if (b_en[g]) begin
                if (b_we[g] != 4'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (b_we[g][b]) mem[b_addr[g][9:2]][8*b +: 8] <= b_din[g][8*b +: 8];
                end else begin
                    pipe[0] <= mem[b_addr[g][9:2]];
                end
            end
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign b_dout[g] = pipe[L-1];
    end

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h", name, inst, act, exp);
        end
    endtask

    // Reference model: who owns the port, whose turn it is, and which reads are in flight.
    typedef struct {
        bit          v;
        bit          id;
        logic [31:0] data;
    } rd_t;

    rd_t         hist [$];
    logic [31:0] gold [0:255];
    int          owner;
    int          held;
    bit          prio_m;
    bit          lerr_exp;

    initial begin : compare
        bit          eg0, eg1, rel, lerr_n;
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        rd_t         e, n;
        int          lat;
        owner = -1; held = 0; prio_m = 0; lerr_exp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    chk("rst_gnt0", i, 64'(g0[i]), 0);
                    chk("rst_gnt1", i, 64'(g1[i]), 0);
                    chk("rst_rvalid", i, 64'({rv0[i], rv1[i]}), 0);
                    chk("rst_lock_err", i, 64'(lerr[i]), 0);
                    chk("rst_bram", i, {b_en[i], b_we[i], b_addr[i]}, 0);
                    chk("rst_bram_din", i, 64'(b_din[i]), 0);
                    chk("rst_bram_rst", i, 64'(b_rst[i]), 1);
                end
                owner = -1; held = 0; prio_m = 0; lerr_exp = 0;
                hist.delete();
            end else begin
                eg0 = 0; eg1 = 0;
                if (owner == 0)      eg0 = r0_req;
                else if (owner == 1) eg1 = r1_req;
                else if (r0_req && r1_req) begin eg0 = !prio_m; eg1 = prio_m; end
                else begin eg0 = r0_req; eg1 = r1_req; end
                ea = eg1 ? r1_addr : (eg0 ? r0_addr : 32'd0);
                ew = eg1 ? r1_we   : (eg0 ? r0_we   : 4'd0);
                ed = eg1 ? r1_din  : (eg0 ? r0_din  : 32'd0);
                for (int i = 0; i < 2; i++) begin
                    lat = (i == 0) ? 1 : 3;
                    chk("gnt0", i, 64'(g0[i]), 64'(eg0));
                    chk("gnt1", i, 64'(g1[i]), 64'(eg1));
                    chk("bram_en", i, 64'(b_en[i]), 64'(eg0 | eg1));
                    chk("bram_addr", i, 64'(b_addr[i]), 64'(ea));
                    chk("bram_we", i, 64'(b_we[i]), 64'(ew));
                    chk("bram_din", i, 64'(b_din[i]), 64'(ed));
                    chk("bram_rst", i, 64'(b_rst[i]), 0);
                    chk("lock_err", i, 64'(lerr[i]), 64'(lerr_exp));
                    e.v = 0; e.id = 0; e.data = 0;
                    if (hist.size() >= lat) e = hist[hist.size() - lat];
                    chk("rvalid0", i, 64'(rv0[i]), 64'(e.v && !e.id));
                    chk("rvalid1", i, 64'(rv1[i]), 64'(e.v && e.id));
                    if (e.v) chk("rdata", i, 64'(e.id ? d1[i] : d0[i]), 64'(e.data));
                end
                n.v = (eg0 | eg1) && (ew == 4'd0);
                n.id = eg1;
                n.data = gold[ea[9:2]];
                if ((eg0 | eg1) && ew != 4'd0)
                    for (int b = 0; b < 4; b++)
                        if (ew[b]) gold[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
                hist.push_back(n);
                if (hist.size() > 4) void'(hist.pop_front());
                lerr_n = 0;
                if (eg0) prio_m = 1;
                if (eg1) prio_m = 0;
                if (owner < 0) begin
                    if (eg0 && r0_lock) begin owner = 0; held = 0; end
                    else if (eg1 && r1_lock) begin owner = 1; held = 0; end
                end else begin
                    rel = (owner == 0) ? (eg0 && !r0_lock) : (eg1 && !r1_lock);
                    if (rel) owner = -1;
                    else if (held == MAXL - 1) begin
                        prio_m = (owner == 0);
                        owner = -1;
                        lerr_n = 1;
                    end else held++;
                end
                lerr_exp = lerr_n;
            end
        end
    end

    task automatic set0(input logic req, input logic lock, input logic [31:0] addr,
                        input logic [3:0] we, input logic [31:0] din);
        r0_req = req; r0_lock = lock; r0_addr = addr; r0_we = we; r0_din = din;
    endtask

    task automatic set1(input logic req, input logic lock, input logic [31:0] addr,
                        input logic [3:0] we, input logic [31:0] din);
        r1_req = req; r1_lock = lock; r1_addr = addr; r1_we = we; r1_din = din;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] p_g0, p_g1, p_rv0a, p_rv1a, p_rv0b, p_rv1b, p_le;

    initial begin : stimulus
        rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) cyc();
        rst = 1'b0;

        // single requester write then read back
        set0(1, 0, 32'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk); chk("single_wr_gnt", 0, 64'(g0[0]), 1);
        cyc();
        set0(1, 0, 32'h10, 4'h0, 32'h0);
        @(negedge clk); chk("single_rd_gnt", 0, 64'(g0[0]), 1);
        cyc();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("single_rv_lat1", 0, 64'(rv0[0]), 1);
        chk("single_dout_lat1", 0, 64'(d0[0]), 64'h0000_0000_DEAD_BEEF);
        cyc();
        set1(1, 0, 32'h40, 4'hF, 32'h0BADF00D);
        cyc();
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("single_rv_lat3", 1, 64'(rv0[1]), 1);
        chk("single_dout_lat3", 1, 64'(d0[1]), 64'h0000_0000_DEAD_BEEF);
        cyc();

        // contention after a fresh reset
        rst = 1'b1; repeat (2) cyc(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                set0(1, 0, 32'h10, 0, 0);
                set1(1, 0, 32'h40, 0, 0);
            end else begin
                set0(0, 0, 0, 0, 0);
                set1(0, 0, 0, 0, 0);
            end
            @(negedge clk);
            p_g0[k] = g0[0]; p_g1[k] = g1[0];
            p_rv0a[k] = rv0[0]; p_rv1a[k] = rv1[0];
            p_rv0b[k] = rv0[1]; p_rv1b[k] = rv1[1];
            cyc();
        end
        chk("cont_gnt0", 0, 64'(p_g0[7:0]), 64'h05);
        chk("cont_gnt1", 0, 64'(p_g1[7:0]), 64'h0A);
        chk("cont_rv0", 0, 64'(p_rv0a[7:0]), 64'h0A);
        chk("cont_rv1", 0, 64'(p_rv1a[7:0]), 64'h14);
        chk("cont_rv0", 1, 64'(p_rv0b[7:0]), 64'h28);
        chk("cont_rv1", 1, 64'(p_rv1b[7:0]), 64'h50);

        // r1 lock burst while r0 keeps asking
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set1(1, (k < 3), 32'h40, 0, 0); else set1(0, 0, 0, 0, 0);
            if (k >= 1) set0(1, 0, 32'h10, 0, 0);
            @(negedge clk);
            p_g0[k] = g0[1]; p_g1[k] = g1[1];
            cyc();
        end
        set0(0, 0, 0, 0, 0);
        chk("lock_gnt0", 1, 64'(p_g0[4:0]), 64'h10);
        chk("lock_gnt1", 1, 64'(p_g1[4:0]), 64'h0F);
        repeat (3) cyc();

        // lock timeout: r0 locks then idles, r1 waits
        for (int k = 0; k < 12; k++) begin
            set0(k == 0, (k < 11), 32'h10, 0, 0);
            if (k >= 1 && k <= 9) set1(1, 0, 32'h40, 0, 0); else set1(0, 0, 0, 0, 0);
            @(negedge clk);
            p_g1[k] = g1[0]; p_le[k] = lerr[0];
            cyc();
        end
        set0(0, 0, 0, 0, 0);
        chk("timeout_lock_err", 0, 64'(p_le), 64'h200);
        chk("timeout_gnt1", 0, 64'(p_g1), 64'h200);
        repeat (3) cyc();

        // reset while a read is in flight; r1 keeps requesting through reset
        for (int k = 0; k < 9; k++) begin
            set0(k == 0, 0, 32'h10, 0, 0);
            set1(k >= 1 && k <= 3, 0, 32'h40, 0, 0);
            rst = (k == 1 || k == 2);
            @(negedge clk);
            p_rv0a[k] = rv0[0]; p_rv0b[k] = rv0[1]; p_g1[k] = g1[1];
            cyc();
        end
        chk("midrst_rv0", 0, 64'(p_rv0a[8:1]), 0);
        chk("midrst_rv0", 1, 64'(p_rv0b[8:1]), 0);
        chk("midrst_gnt1", 1, 64'(p_g1[8:0]), 64'h008);

        // partial byte write then read back
        set1(1, 0, 32'h20, 4'hF, 32'hFFFFFFFF);
        cyc();
        set1(1, 0, 32'h20, 4'b0011, 32'h00001234);
        cyc();
        set1(1, 0, 32'h20, 4'h0, 32'h0);
        cyc();
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("partial_rv1", 0, 64'(rv1[0]), 1);
        chk("partial_dout", 0, 64'(d1[0]), 64'h0000_0000_FFFF_1234);
        repeat (2) cyc();
        @(negedge clk);
        chk("partial_dout", 1, 64'(d1[1]), 64'h0000_0000_FFFF_1234);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
